// File: rtl/parking_slot_allocator.sv
`default_nettype none
// ============================================================================
// Module      : parking_slot_allocator
// Description : Eight-slot car park allocator that grants the lowest free slot
//               on entry, releases a named slot on exit, and drives the barrier.
//               Macro GATE_HOLD_EN enables the GATE hold state and gate_open.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_slot_allocator #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_slot,
    output logic [7:0] Cars,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       entry_ack,
    output logic [2:0] entry_slot,
    output logic       exit_ack,
    output logic       err,
    output logic       gate_open
);

    if (GATE_CYCLES < 1 || GATE_CYCLES > 15) begin : g_gate_cycles_illegal
        $error("parking_slot_allocator: GATE_CYCLES must be within 1..15");
    end

    logic [7:0] r_cars;
    logic [3:0] r_count;
    logic       r_full;
    logic       r_empty;
    logic [2:0] r_entry_slot;
    logic       r_entry_ack;
    logic       r_exit_ack;
    logic       r_err;

    logic [7:0] w_cars_nxt;
    logic [3:0] w_count_nxt;
    logic [2:0] w_slot_nxt;
    logic       w_entry_ack_nxt;
    logic       w_exit_ack_nxt;
    logic       w_err_nxt;
    logic       w_accept;
    logic       w_sample;
    logic [2:0] w_free_idx;

`ifdef GATE_HOLD_EN
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam logic [3:0] c_gate_last = 4'(GATE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_gate_cnt;
    logic [3:0] w_gate_cnt_nxt;
    logic       r_gate_open;
    logic       w_gate_open_nxt;

    assign w_sample  = (r_state == IDLE);
    assign gate_open = r_gate_open;
`else
    assign w_sample  = 1'b1;
    assign gate_open = 1'b0;
`endif

    // Lowest-index clear slot; only meaningful when not full.
    always_comb begin
        w_free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!r_cars[i]) begin
                w_free_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_count_nxt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_count_nxt = w_count_nxt + {3'b000, w_cars_nxt[i]};
        end
    end

    // Exit is examined first so it wins over a simultaneous entry.
    always_comb begin
        w_cars_nxt      = r_cars;
        w_slot_nxt      = r_entry_slot;
        w_entry_ack_nxt = 1'b0;
        w_exit_ack_nxt  = 1'b0;
        w_err_nxt       = 1'b0;
        w_accept        = 1'b0;
        if (w_sample) begin
            if (exit_req) begin
                if (r_cars[exit_slot]) begin
                    w_cars_nxt[exit_slot] = 1'b0;
                    w_exit_ack_nxt        = 1'b1;
                    w_accept              = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end else if (entry_req) begin
                if (!r_full) begin
                    w_cars_nxt[w_free_idx] = 1'b1;
                    w_slot_nxt             = w_free_idx;
                    w_entry_ack_nxt        = 1'b1;
                    w_accept               = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
        end
    end

`ifdef GATE_HOLD_EN
    // The accepting edge loads the hold counter; gate_open drops as GATE exits.
    always_comb begin
        w_state_nxt     = r_state;
        w_gate_cnt_nxt  = r_gate_cnt;
        w_gate_open_nxt = r_gate_open;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = GATE;
                    w_gate_cnt_nxt  = c_gate_last;
                    w_gate_open_nxt = 1'b1;
                end
            end
            GATE: begin
                if (r_gate_cnt == 4'd0) begin
                    w_state_nxt     = IDLE;
                    w_gate_open_nxt = 1'b0;
                end else begin
                    w_gate_cnt_nxt = r_gate_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_gate_open_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gate_cnt  <= 4'd0;
            r_gate_open <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gate_cnt  <= w_gate_cnt_nxt;
            r_gate_open <= w_gate_open_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cars       <= 8'h00;
            r_count      <= 4'd0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_entry_slot <= 3'd0;
            r_entry_ack  <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cars       <= w_cars_nxt;
            r_count      <= w_count_nxt;
            r_full       <= (w_count_nxt == 4'd8);
            r_empty      <= (w_count_nxt == 4'd0);
            r_entry_slot <= w_slot_nxt;
            r_entry_ack  <= w_entry_ack_nxt;
            r_exit_ack   <= w_exit_ack_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign Cars       = r_cars;
    assign count      = r_count;
    assign full       = r_full;
    assign empty      = r_empty;
    assign entry_slot = r_entry_slot;
    assign entry_ack  = r_entry_ack;
    assign exit_ack   = r_exit_ack;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/parking_slot_allocator.md
PARKING_SLOT_ALLOCATOR -- requirements
Module: parking_slot_allocator

Interface
REQ-001 The module SHALL have parameter GATE_CYCLES, default 4, meaning the number of cycles gate_open stays high per accepted request (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The module SHALL have port entry_req, input, 1, a level request to park one car.
REQ-005 The module SHALL have port exit_req, input, 1, a level request to release the slot given by exit_slot.
REQ-006 The module SHALL have port exit_slot, input, 3, the slot index being vacated.
REQ-007 The module SHALL have port Cars, output, 8, the occupancy vector (bit i = 1 means slot i occupied), driven to the 7-segment occupancy display.
REQ-008 The module SHALL have port count, output, 4, the number of occupied slots (0..8).
REQ-009 The module SHALL have ports full, output, 1 and empty, output, 1, meaning count==8 and count==0 respectively.
REQ-010 The module SHALL have ports entry_ack, output, 1 and entry_slot, output, 3, a one-cycle grant pulse and the slot index assigned.
REQ-011 The module SHALL have port exit_ack, output, 1, a one-cycle release pulse.
REQ-012 The module SHALL have ports err, output, 1, a one-cycle reject pulse, and gate_open, output, 1, the barrier drive.

Function
REQ-013 The FSM SHALL have the states IDLE and GATE; requests SHALL be sampled only in IDLE and ignored in GATE.
REQ-014 In IDLE, when exit_req=1 and Cars[exit_slot]=1, the module SHALL clear that bit, pulse exit_ack, and enter GATE.
REQ-015 In IDLE, when exit_req=1 and Cars[exit_slot]=0, the module SHALL pulse err, leave Cars unchanged, and stay in IDLE.
REQ-016 In IDLE, when exit_req=0 and entry_req=1 with full=0, the module SHALL set the lowest-index clear bit of Cars, drive that index on entry_slot, pulse entry_ack, and enter GATE.
REQ-017 In IDLE, when exit_req=0 and entry_req=1 with full=1, the module SHALL pulse err and stay in IDLE.
REQ-018 When entry_req and exit_req are both high in IDLE, exit SHALL take priority; the entry SHALL be served at the next IDLE sample if entry_req is still high.
REQ-019 All outputs SHALL be registered, with Cars, count, full, empty, acks, err and entry_slot updating at the accepting edge (one-cycle latency).
REQ-020 count SHALL always equal the popcount of Cars in the same cycle, and full and empty SHALL be consistent with count.
REQ-021 entry_slot SHALL hold its last value between grants.
REQ-022 GATE SHALL last exactly GATE_CYCLES cycles with gate_open=1 and then return to IDLE, so accepted requests are at least GATE_CYCLES+1 edges apart.
REQ-023 A requester that keeps its request high after the ack SHALL be served again at the next IDLE sample; requesters drop their request on ack.

Reset
REQ-024 When rst=1 at an edge, the module SHALL set state to IDLE, Cars=0, count=0, empty=1, full=0, entry_slot=0, and entry_ack, exit_ack, err and gate_open to 0.
REQ-025 Reset SHALL take priority over any request and SHALL abort a GATE period in progress.

Configuration
REQ-026 With macro GATE_HOLD_EN defined, the GATE state and gate_open timing SHALL be as specified above.
REQ-027 Without GATE_HOLD_EN, the GATE state SHALL be absent, gate_open SHALL be tied to 0, the module SHALL stay in IDLE, and requests SHALL be accepted on every edge.

Verification
REQ-028 Scenario: reset, then entry_req held until ack, three times -> Cars=8'b00000111, count=3, entry_slot=0,1,2, one gate_open burst of 4 cycles per grant.
REQ-029 Scenario: with Cars=8'b00000111, exit_req with exit_slot=1, then entry_req -> Cars=8'b00000101, exit_ack; then Cars=8'b00000111, entry_slot=1.
REQ-030 Scenario: 8 entries -> full=1, Cars=8'hFF; a 9th entry_req -> err pulse, Cars unchanged, gate_open stays 0.
REQ-031 Scenario: exit_req with exit_slot=5 while Cars=8'h01 -> err pulse, no exit_ack, Cars=8'h01.
REQ-032 Scenario: entry_req and exit_req (slot 0) high together with Cars=8'h01 -> exit served first (Cars=8'h00); after GATE, entry served (Cars=8'h01).
REQ-033 Scenario: rst asserted on the second GATE cycle -> next cycle all outputs at reset values, and the FSM accepts a new request on the following edge.
